overlay_mixer: RTL and testbench
================================

Name: overlay_mixer

Overview:
- Pixel-pipeline stage directly downstream of the emblem overlay generator.
- Composites the generator's 6-bit RRGGBB overlay over the background pixel, keying out the transparent colour.
- Applies a frame-synchronous fade-in/fade-out alpha.
- Registers the result with matched sync delay before the VGA output pins.

Parameters:
SYNC_POL, 1'b0, active level of hsync/vsync (0 = active-low, 640x480 VGA)
FADE_FRAMES, 8, frame events per alpha step; legal 1..255
KEY_COLOR, 6'b100001, overlay value treated as transparent

Ports:
clk  input  1  pixel clock
rst  input  1  reset; asynchronous, active-high
show  input  1  request overlay visible (level, sampled only at frame events)
bg_rgb  input  6  background pixel RRGGBB
ov_rgb  input  6  overlay pixel RRGGBB from the emblem generator
active_in  input  1  visible-area flag aligned with bg_rgb/ov_rgb
hsync_in  input  1  horizontal sync aligned with pixel inputs
vsync_in  input  1  vertical sync aligned with pixel inputs
rgb_out  output  6  composited pixel, registered
hsync_out  output  1  hsync_in delayed 1 cycle
vsync_out  output  1  vsync_in delayed 1 cycle
active_out  output  1  active_in delayed 1 cycle
fade_level  output  3  current alpha level L, 0..4
fade_busy  output  1  high in FADE_IN or FADE_OUT

Behaviour:
- Reset (async, immediate):
  - rgb_out=0, active_out=0, hsync_out=vsync_out=~SYNC_POL.
  - State HIDDEN, L=0, frame counter=0, vsync history=~SYNC_POL.
- Latency: exactly 1 clk from inputs to rgb_out/hsync_out/vsync_out/active_out. No stalls or backpressure.
- Frame event: single-cycle internal pulse when registered vsync_in was ~SYNC_POL and current vsync_in == SYNC_POL.
  - State, L and counter change only on frame events, so no tearing inside the visible area.
- Compositing, evaluated combinationally and registered:
  - active_in=0 -> rgb_out=0.
  - ov_rgb==KEY_COLOR -> bg_rgb, regardless of L.
  - Otherwise, per 2-bit channel c: out_c = (ov_c*L + bg_c*(4-L)) >> 2.
    - 4-bit intermediate, truncating.
    - L=0 gives bg exactly; L=4 gives ov exactly.
- State machine (transitions on frame events only):
  - HIDDEN (L=0):
    - show=1 -> FADE_IN, counter=0.
  - FADE_IN:
    - show=0 -> FADE_OUT, counter=0, L unchanged.
    - Else if counter==FADE_FRAMES-1: counter=0, L=L+1; if new L==4 -> SHOWN.
    - Else counter+1.
  - SHOWN (L=4):
    - show=0 -> FADE_OUT, counter=0.
  - FADE_OUT: mirror of FADE_IN.
    - Decrement L; reaching 0 -> HIDDEN.
    - show=1 -> FADE_IN, counter=0.
- Boundaries:
  - Reversal mid-fade keeps L and restarts the counter.
  - L never leaves 0..4.
  - FADE_FRAMES=1 steps L on every frame event.
  - show toggling between frame events is ignored.
- fade_level and fade_busy are registered state outputs, not delayed with pixels.

Optional Feature:
OVERLAY_FADE_EN
- Defined: full fade state machine as above.
- Undefined:
  - No FADE_IN/FADE_OUT states and no frame counter.
  - On each frame event, L jumps directly: 4 if show=1, else 0.
  - fade_busy tied 0; FADE_FRAMES ignored.
  - Compositing, keying and latency unchanged.

Test Plan:
1. rst pulsed mid-frame with SHOWN state -> same cycle: rgb_out=000000, hsync_out=vsync_out=1, active_out=0, fade_level=0, fade_busy=0.
2. show=0, active_in=1, bg=010101, ov=111111 -> rgb_out=010101 one clk later; hsync/vsync/active delayed exactly 1 clk.
3. FADE_FRAMES=2, OVERLAY_FADE_EN defined, show=1, bg=000000, ov=111111 from HIDDEN:
   - Frame event 1 enters FADE_IN.
   - L=1 after event 3 (rgb 000000), L=2 after event 5 (rgb 010101), L=3 after event 7 (rgb 101010), L=4 after event 9 (rgb 111111, SHOWN, fade_busy=0).
4. SHOWN, ov=100001, bg=001100 -> rgb_out=001100. active_in=0 with any inputs -> rgb_out=000000.
5. FADE_FRAMES=2, at L=2 in FADE_IN drop show -> next frame event enters FADE_OUT with L=2; L=1 two events later; L=0/HIDDEN two events after that.
6. OVERLAY_FADE_EN undefined, show=1 -> fade_level 0->4 on first frame event, fade_busy stays 0; show=0 -> 4->0 on next frame event.

Source files
------------

// File: rtl/overlay_mixer.sv
// overlay_mixer: composites the emblem generator's RRGGBB overlay over the
// background pixel with a key colour and a frame-synchronous alpha level L
// (0..4), then registers pixel and syncs with a matched one-cycle delay.
//
// Build option: define OVERLAY_FADE_EN for the stepped fade state machine
// (HIDDEN / FADE_IN / SHOWN / FADE_OUT with a frame counter).  Without it,
// L jumps straight to 4 or 0 on each frame event and fade_busy is tied low.
//
// Handshake: none.  The pixel path is a free-running one-cycle pipeline with
// no valid/ready, no stalls and no backpressure; every clock moves a pixel.
module overlay_mixer #(
  parameter logic       SYNC_POL    = 1'b0,
  parameter int         FADE_FRAMES = 8,
  parameter logic [5:0] KEY_COLOR   = 6'b100001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       show,
  input  logic [5:0] bg_rgb,
  input  logic [5:0] ov_rgb,
  input  logic       active_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [5:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       active_out,
  output logic [2:0] fade_level,
  output logic       fade_busy
);

  // Elaboration-time guard on the fade step length.
  if (FADE_FRAMES < 1 || FADE_FRAMES > 255) begin : g_bad_fade_frames
    $error("overlay_mixer: FADE_FRAMES must be in 1..255");
  end

  logic [5:0] rgb_q;
  logic       hsync_q;
  logic       vsync_q;
  logic       active_q;
  logic       vs_hist_q;
  logic [2:0] level_q;
  logic [2:0] level_d;
  logic       frame_evt;

  // Frame event: vsync just entered its active level.
  assign frame_evt = (vs_hist_q == ~SYNC_POL) && (vsync_in == SYNC_POL);

  logic [5:0] mix_d;
  logic [2:0] inv_level;
  logic [3:0] acc;

  // Per-channel blend (ov*L + bg*(4-L)) >> 2, with keying and blanking.
  always_comb begin
    mix_d     = '0;
    acc       = '0;
    inv_level = 3'd4 - level_q;
    if (!active_in) begin
      mix_d = '0;
    end else if (ov_rgb == KEY_COLOR) begin
      mix_d = bg_rgb;
    end else begin
      for (int c = 0; c < 3; c++) begin
        acc = {2'b00, ov_rgb[2*c +: 2]} * {1'b0, level_q}
            + {2'b00, bg_rgb[2*c +: 2]} * {1'b0, inv_level};
        mix_d[2*c +: 2] = acc[3:2];
      end
    end
  end

  // Pixel and sync pipeline register; syncs idle at their inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q    <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b0;
    end else begin
      rgb_q    <= mix_d;
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      active_q <= active_in;
    end
  end

`ifdef OVERLAY_FADE_EN
  localparam logic [1:0] ST_HIDDEN   = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_SHOWN    = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;
  localparam logic [7:0] CNT_LAST    = 8'(FADE_FRAMES - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);

  // Fade state machine; advances only on frame events.  A step saturates L
  // at 4 / 0 so a reversal at either end cannot push L out of range.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (frame_evt) begin
      case (state_q)
        ST_HIDDEN: begin
          if (show) begin
            state_d = ST_FADE_IN;
            cnt_d   = '0;
          end
        end
        ST_FADE_IN: begin
          if (!show) begin
            state_d = ST_FADE_OUT;
            cnt_d   = '0;
          end else if (cnt_done) begin
            cnt_d = '0;
            if (level_q >= 3'd3) begin
              level_d = 3'd4;
              state_d = ST_SHOWN;
            end else begin
              level_d = level_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_SHOWN: begin
          if (!show) begin
            state_d = ST_FADE_OUT;
            cnt_d   = '0;
          end
        end
        default: begin
          if (show) begin
            state_d = ST_FADE_IN;
            cnt_d   = '0;
          end else if (cnt_done) begin
            cnt_d = '0;
            if (level_q <= 3'd1) begin
              level_d = 3'd0;
              state_d = ST_HIDDEN;
            end else begin
              level_d = level_q - 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Fade state and frame counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HIDDEN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fade_busy = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);
`else
  // Without fading, L snaps to fully shown or hidden at each frame event.
  always_comb begin
    level_d = level_q;
    if (frame_evt) begin
      level_d = show ? 3'd4 : 3'd0;
    end
  end

  assign fade_busy = 1'b0;
`endif

  // Alpha level and vsync history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 3'd0;
      vs_hist_q <= ~SYNC_POL;
    end else begin
      level_q   <= level_d;
      vs_hist_q <= vsync_in;
    end
  end

  assign rgb_out    = rgb_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign active_out = active_q;
  assign fade_level = level_q;

endmodule

// File: tb/tb_overlay_mixer.sv
// tb_overlay_mixer: scoreboard bench for overlay_mixer.  A behavioural model
// tracks the alpha level; each driven pixel pushes its expected registered
// output, which is popped and compared one clock later.
module tb_overlay_mixer;
  localparam int         FF   = 2;
  localparam logic       SP   = 1'b0;
  localparam logic [5:0] KEY  = 6'b100001;
`ifdef OVERLAY_FADE_EN
  localparam int EV_TO_SHOW = 4 * FF + 1;
`else
  localparam int EV_TO_SHOW = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       show;
  logic [5:0] bg_rgb;
  logic [5:0] ov_rgb;
  logic       active_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [5:0] rgb_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       active_out;
  logic [2:0] fade_level;
  logic       fade_busy;

  always #5 clk = ~clk;

  overlay_mixer #(
    .SYNC_POL   (SP),
    .FADE_FRAMES(FF),
    .KEY_COLOR  (KEY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .show      (show),
    .bg_rgb    (bg_rgb),
    .ov_rgb    (ov_rgb),
    .active_in (active_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .rgb_out   (rgb_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .active_out(active_out),
    .fade_level(fade_level),
    .fade_busy (fade_busy)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];  // {rgb, hsync, vsync, active}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_l;
  int   m_state;  // 0 hidden, 1 fade in, 2 shown, 3 fade out
  int   m_cnt;
  logic m_vs_hist;

  function automatic logic [5:0] mix(input logic [5:0] bg, input logic [5:0] ov,
                                     input logic act, input int l);
    logic [5:0] r;
    int o, b;
    r = '0;
    if (!act) return 6'd0;
    if (ov == KEY) return bg;
    for (int c = 0; c < 3; c++) begin
      o = int'(ov[2*c +: 2]);
      b = int'(bg[2*c +: 2]);
      r[2*c +: 2] = 2'((o * l + b * (4 - l)) / 4);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_l       = 0;
    m_state   = 0;
    m_cnt     = 0;
    m_vs_hist = ~SP;
  endtask

  task automatic model_step(input logic s, input logic vs);
    if (m_vs_hist == ~SP && vs == SP) begin
`ifdef OVERLAY_FADE_EN
      case (m_state)
        0: if (s) begin m_state = 1; m_cnt = 0; end
        1: begin
          if (!s) begin m_state = 3; m_cnt = 0; end
          else if (m_cnt == FF - 1) begin
            m_cnt = 0;
            if (m_l < 4) m_l++;
            if (m_l == 4) m_state = 2;
          end else m_cnt++;
        end
        2: if (!s) begin m_state = 3; m_cnt = 0; end
        default: begin
          if (s) begin m_state = 1; m_cnt = 0; end
          else if (m_cnt == FF - 1) begin
            m_cnt = 0;
            if (m_l > 0) m_l--;
            if (m_l == 0) m_state = 0;
          end else m_cnt++;
        end
      endcase
`else
      m_l = s ? 4 : 0;
`endif
    end
    m_vs_hist = vs;
  endtask

  function automatic logic model_busy();
    return (m_state == 1) || (m_state == 3);
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; drives one pixel and checks it next edge.
  task automatic cycle(input logic s, input logic [5:0] bg, input logic [5:0] ov,
                       input logic act, input logic hs, input logic vs);
    logic [8:0] e;
    show      = s;
    bg_rgb    = bg;
    ov_rgb    = ov;
    active_in = act;
    hsync_in  = hs;
    vsync_in  = vs;
    exp_q.push_back({mix(bg, ov, act, m_l), hs, vs, act});
    model_step(s, vs);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("pixel", {23'd0, rgb_out, hsync_out, vsync_out, active_out}, {23'd0, e});
    end
    check_eq("fade_level", {29'd0, fade_level}, 32'(m_l));
    check_eq("fade_busy", {31'd0, fade_busy}, {31'd0, model_busy()});
  endtask

  task automatic rand_pixel(input logic s, input logic vs);
    cycle(s, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), vs);
  endtask

  // One frame event followed by a few idle-vsync pixels.
  task automatic frame(input logic s, input logic [5:0] bg, input logic [5:0] ov);
    cycle(s, bg, ov, 1'b1, 1'b1, SP);
    repeat ($urandom_range(1, 3)) cycle(s, bg, ov, 1'b1, 1'($urandom_range(0, 1)), ~SP);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; show = 1'b0; bg_rgb = '0; ov_rgb = '0;
    active_in = 1'b0; hsync_in = ~SP; vsync_in = ~SP;
    model_reset();
    #12;
    check_eq("rst_rgb", {26'd0, rgb_out}, 32'd0);
    check_eq("rst_syncs", {30'd0, hsync_out, vsync_out}, 32'd3);
    check_eq("rst_active", {31'd0, active_out}, 32'd0);
    check_eq("rst_level", {29'd0, fade_level}, 32'd0);
    check_eq("rst_busy", {31'd0, fade_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Hidden overlay passes background through; syncs delayed one clock.
    cycle(1'b0, 6'b010101, 6'b111111, 1'b1, 1'b0, 1'b1);
    check_eq("hidden_bg", {26'd0, rgb_out}, 32'h15);
    cycle(1'b0, 6'b010101, 6'b111111, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 6'b010101, 6'b111111, 1'b0, 1'b0, 1'b1);
    repeat (20) rand_pixel(1'b0, ~SP);

    // Fade in against black background / white overlay.
    repeat (EV_TO_SHOW) frame(1'b1, 6'b000000, 6'b111111);
    check_eq("shown_level", {29'd0, fade_level}, 32'd4);
    check_eq("shown_rgb", {26'd0, rgb_out}, 32'h3f);

    // Keying and blanking while shown.
    cycle(1'b1, 6'b001100, KEY, 1'b1, 1'b1, ~SP);
    check_eq("key_bg", {26'd0, rgb_out}, 32'h0c);
    cycle(1'b1, 6'b111111, 6'b101010, 1'b0, 1'b1, ~SP);
    check_eq("blank", {26'd0, rgb_out}, 32'd0);
    repeat (20) rand_pixel(1'b1, ~SP);

    // show toggling between frame events must not move L.
    for (int i = 0; i < 12; i++) rand_pixel(1'(i % 2), ~SP);

    // Fade out with a mid-fade reversal, then finish hiding.
    frame(1'b0, 6'b000000, 6'b111111);
    repeat (FF) frame(1'b0, 6'b011011, 6'b110001);
    frame(1'b1, 6'b000000, 6'b111111);
    frame(1'b0, 6'b000000, 6'b111111);
    repeat (EV_TO_SHOW + 2) frame(1'b0, 6'b100100, 6'b010111);
    check_eq("hidden_level", {29'd0, fade_level}, 32'd0);

    // Random show / vsync / pixel mix.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) show = ~show;
      rand_pixel(show, 1'($urandom_range(0, 5) != 0) ^ SP);
    end

    // Reach shown, then reset asynchronously mid-cycle.
    cycle(1'b1, 6'b0, 6'b0, 1'b0, 1'b1, ~SP);
    repeat (EV_TO_SHOW) frame(1'b1, 6'b010101, 6'b101010);
    cycle(1'b1, 6'b010101, 6'b101010, 1'b1, 1'b0, SP);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_rgb", {26'd0, rgb_out}, 32'd0);
    check_eq("arst_syncs", {30'd0, hsync_out, vsync_out}, 32'd3);
    check_eq("arst_active", {31'd0, active_out}, 32'd0);
    check_eq("arst_level", {29'd0, fade_level}, 32'd0);
    check_eq("arst_busy", {31'd0, fade_busy}, 32'd0);
    exp_q.delete();
    model_reset();
    vsync_in = ~SP;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (10) rand_pixel(1'b0, ~SP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
